// File: rtl/odd_even_pkg.sv
// odd_even_pkg
// Shared definitions for the odd/even counter-sequence checker:
//   state_t        - checker FSM states (HUNT, SYNC, LOCKED)
//   DEF_WIDTH      - default sample width
//   DEF_LOCK_COUNT - default number of consecutive matches needed to lock
//   ERR_CNT_W      - width of the saturating error counter
//   MATCH_W        - width of the match counter (holds LOCK_COUNT up to 15)
package odd_even_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_LOCK_COUNT = 3;
   localparam int ERR_CNT_W      = 8;
   localparam int MATCH_W        = 4;

endpackage

// File: rtl/odd_even_checker_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear, wins over inc
//   inc   - increment enable
//   count - current count value
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/odd_even_checker.sv
// odd_even_checker
// Watches a free-running counter that should step by 2 through either the odd
// or the even values of a WIDTH-bit range, locks after LOCK_COUNT consecutive
// correct samples, and reports sequence breaks while locked.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   mode      - 1 = odd sequence, 0 = even sequence
//   in_valid  - in_cnt is sampled this cycle
//   in_cnt    - observed counter value
//   locked    - high while in LOCKED (registered)
//   err_pulse - one-cycle pulse per reported error (registered)
//   err_cnt   - saturating error count
//   expected  - next value predicted for in_cnt
// Build option: ODD_EVEN_CHECKER_FLYWHEEL_EN lets a single miss in LOCKED be
// tolerated (error reported, lock kept, prediction advanced); a second
// consecutive miss drops to HUNT. Without it any miss drops to HUNT.
// Handshake: a sample is consumed on every rising edge where in_valid is high;
// there is no back-pressure, the checker is always ready.
module odd_even_checker
   import odd_even_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0]     expected
);

   state_t             state_q, state_d;
   logic               mode_q;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               err_now;
   logic               hit;
   logic [WIDTH-1:0]   exp_plus2;
   logic [MATCH_W-1:0] match_inc;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
   logic               miss_q, miss_d;
`endif

   // Plain modulo-2^WIDTH addition gives the wrap for both sequences.
   assign hit       = (in_cnt == exp_q);
   assign exp_plus2 = exp_q + WIDTH'(2);
   assign match_inc = match_q + MATCH_W'(1);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      match_d = match_q;
      err_now = 1'b0;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
      miss_d  = miss_q;
`endif
      if (mode != mode_q) begin
         // A sequence change invalidates any lock; the sample is dropped.
         state_d = HUNT;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
         miss_d  = 1'b0;
`endif
      end else if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_cnt[0] == mode) begin
                  exp_d   = in_cnt + WIDTH'(2);
                  match_d = MATCH_W'(1);
                  state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
               end
            end
            SYNC: begin
               if (hit) begin
                  match_d = match_inc;
                  exp_d   = exp_plus2;
                  if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                     state_d = LOCKED;
                  end
               end else begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               if (hit) begin
                  exp_d  = exp_plus2;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
                  miss_d = 1'b0;
`endif
               end else begin
                  err_now = 1'b1;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
                  if (!miss_q) begin
                     // Coast over one bad sample on the predicted sequence.
                     miss_d = 1'b1;
                     exp_d  = exp_plus2;
                  end else begin
                     miss_d  = 1'b0;
                     state_d = HUNT;
                  end
`else
                  state_d = HUNT;
`endif
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT;
         mode_q    <= mode;
         exp_q     <= '0;
         match_q   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
         miss_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mode_q    <= mode;
         exp_q     <= exp_d;
         match_q   <= match_d;
         locked    <= (state_d == LOCKED);
         err_pulse <= err_now;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
         miss_q    <= miss_d;
`endif
      end
   end

   assign expected = exp_q;

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (err_now),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_odd_even_checker.sv
// tb_odd_even_checker
// Self-checking bench for odd_even_checker (WIDTH=4, LOCK_COUNT=3): directed
// scenarios plus randomized traffic, every cycle compared against a
// behavioural model of the sequence rules.
module tb_odd_even_checker;

   localparam int WIDTH = 4;
   localparam int LC    = 3;
   localparam int M     = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             mode = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_cnt = '0;
   logic             locked;
   logic             err_pulse;
   logic [7:0]       err_cnt;
   logic [WIDTH-1:0] expected;

   int n_vec  = 0;
   int n_fail = 0;

   // behavioural model state
   bit m_mode;
   bit m_locked;
   bit m_pulse;
   bit m_missed;
   int m_run;
   int m_nxt;
   int m_errs;

   always #5 clk = ~clk;

   odd_even_checker #(
      .WIDTH      (WIDTH),
      .LOCK_COUNT (LC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_cnt    (in_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .expected  (expected)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model: a run of valid samples of the right parity, each 2 above the
   // previous (mod M), locks once it reaches LC samples.
   task automatic model_update(input bit r, input bit m, input bit v, input int c);
      m_pulse = 1'b0;
      if (r) begin
         m_mode = m; m_locked = 0; m_run = 0; m_nxt = 0; m_errs = 0; m_missed = 0;
      end else if (m != m_mode) begin
         m_mode = m; m_locked = 0; m_run = 0; m_missed = 0;
      end else if (v) begin
         if (!m_locked) begin
            if (m_run == 0) begin
               if ((c % 2) == int'(m)) begin
                  m_run = 1;
                  m_nxt = (c + 2) % M;
               end
            end else if (c == m_nxt) begin
               m_run++;
               m_nxt = (m_nxt + 2) % M;
            end else begin
               m_run = 0;
            end
            if (m_run >= LC) m_locked = 1;
         end else if (c == m_nxt) begin
            m_nxt = (m_nxt + 2) % M;
            m_missed = 0;
         end else begin
            m_pulse = 1;
            if (m_errs < 255) m_errs++;
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
            if (!m_missed) begin
               m_missed = 1;
               m_nxt = (m_nxt + 2) % M;
            end else begin
               m_missed = 0; m_locked = 0; m_run = 0;
            end
`else
            m_locked = 0; m_run = 0;
`endif
         end
      end
   endtask

   task automatic step(input bit r, input bit m, input bit v, input int c);
      int cm;
      cm = c % M;
      @(negedge clk);
      rst = r; mode = m; in_valid = v; in_cnt = WIDTH'(cm);
      model_update(r, m, v, cm);
      @(posedge clk);
      #1;
      check("locked",    int'(locked),    int'(m_locked));
      check("err_pulse", int'(err_pulse), int'(m_pulse));
      check("err_cnt",   int'(err_cnt),   m_errs);
      check("expected",  int'(expected),  m_nxt);
   endtask

   initial begin
      int c;
      int forced;
      bit r, m, v;

      // reset state
      step(1, 0, 0, 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check("rst_expected", int'(expected), 0);

      // even lock on 0,2,4
      step(0, 0, 1, 0);
      step(0, 0, 1, 2);
      check("even_not_yet_locked", int'(locked), 0);
      step(0, 0, 1, 4);
      check("even_lock", int'(locked), 1);
      check("even_lock_exp", int'(expected), 6);

      // gap of 5 idle cycles between 4 and 6
      for (int i = 0; i < 5; i++) step(0, 0, 0, $urandom_range(0, M - 1));
      check("gap_locked", int'(locked), 1);
      step(0, 0, 1, 6);
      check("gap_resume_locked", int'(locked), 1);
      check("gap_no_err", int'(err_cnt), 0);
      check("gap_exp8", int'(expected), 8);

      // error: expected 8, feed 9
      step(0, 0, 1, 9);
      check("err_pulse_hi", int'(err_pulse), 1);
      check("err_cnt_1", int'(err_cnt), 1);
`ifdef ODD_EVEN_CHECKER_FLYWHEEL_EN
      check("err_fly_locked", int'(locked), 1);
      check("err_fly_exp", int'(expected), 10);
`else
      check("err_unlocked", int'(locked), 0);
`endif
      step(0, 0, 0, 0);
      check("err_pulse_one_cycle", int'(err_pulse), 0);

      // odd wrap: 11,13,15 -> expected 1, then feed 1
      step(1, 1, 0, 0);
      step(0, 1, 1, 11);
      step(0, 1, 1, 13);
      step(0, 1, 1, 15);
      check("odd_lock", int'(locked), 1);
      check("odd_wrap_exp", int'(expected), 1);
      step(0, 1, 1, 1);
      check("odd_wrap_locked", int'(locked), 1);
      check("odd_wrap_no_err", int'(err_cnt), 0);
      check("odd_wrap_exp3", int'(expected), 3);

      // mode flip while locked even, with a sample present
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 2);
      step(0, 0, 1, 4);
      step(0, 0, 1, 6);
      step(0, 1, 1, 8);
      check("flip_unlocked", int'(locked), 0);
      check("flip_no_pulse", int'(err_pulse), 0);
      check("flip_err_cnt", int'(err_cnt), 0);
      step(0, 1, 1, 3);
      step(0, 1, 1, 5);
      step(0, 1, 1, 7);
      check("flip_relock_odd", int'(locked), 1);

      // saturation: force 260 errors
      step(1, 0, 0, 0);
      forced = 0;
      for (int i = 0; i < 4000 && forced < 260; i++) begin
         if (m_locked)       c = m_nxt + 1;
         else if (m_run == 0) c = 2 * $urandom_range(0, M / 2 - 1);
         else                 c = m_nxt;
         step(0, 0, 1, c);
         if (m_pulse) forced++;
      end
      check("sat_forced_260", forced, 260);
      check("sat_err_cnt", int'(err_cnt), 255);

      // reset together with a valid sample
      step(1, 0, 1, 5);
      check("rst_v_locked", int'(locked), 0);
      check("rst_v_pulse", int'(err_pulse), 0);
      check("rst_v_err_cnt", int'(err_cnt), 0);
      check("rst_v_expected", int'(expected), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         m = ($urandom_range(0, 59) == 0) ? ~m_mode : m_mode;
         v = ($urandom_range(0, 9) < 8);
         if ((m_locked || m_run > 0) && $urandom_range(0, 9) < 8) c = m_nxt;
         else c = $urandom_range(0, M - 1);
         step(r, m, v, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
